// File: rtl/md5_unit_tracker_pkg.sv
// Shared definitions for the MD5 unit tracker: per-unit state encodings and helpers.
// Encodings match the values the MD5 cores and control block expect.
package md5_unit_tracker_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE    = 2'd2;
    localparam logic [STATE_W-1:0] ST_TIMEOUT = 2'd3;

    // A unit parked in DONE or TIMEOUT waits for software to restart or reset it.
    function automatic logic is_final(input logic [STATE_W-1:0] st);
        return (st == ST_DONE) || (st == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/md5_unit_tracker_slot.sv
// One tracked MD5 core: per-unit FSM, RUN-cycle counter, done-edge detector and
// registered start/reset pulses toward the core.
module md5_unit_tracker_slot
    import md5_unit_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic ctl_start_i,
    input  logic ctl_reset_i,
    input  logic core_done_i,
    output logic core_start_o,
    output logic core_reset_o,
    output logic md5_done_o,
    output logic busy_o,
    output logic timeout_o,
    output logic enter_final_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               core_start_q, core_start_d;
    logic               core_reset_q;
    logic               done_edge;

    assign done_edge = core_done_i & ~done_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = core_done_i;
        core_start_d = 1'b0;

        if (ctl_reset_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A start while running is ignored; done beats timeout on the last cycle.
                    if (done_edge) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    if (ctl_start_i) begin
                        state_d      = ST_RUN;
                        cnt_d        = '0;
                        core_start_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign enter_final_o = (state_q == ST_RUN) && is_final(state_d);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            core_start_q <= 1'b0;
            core_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
            core_reset_q <= ctl_reset_i;
        end
    end

    assign core_start_o = core_start_q;
    assign core_reset_o = core_reset_q;
    assign md5_done_o   = (state_q == ST_DONE);
    assign busy_o       = (state_q == ST_RUN);
    assign timeout_o    = (state_q == ST_TIMEOUT);

endmodule

// File: rtl/md5_unit_tracker.sv
// Tracks an array of MD5 cores between the control register block and the cores,
// and raises a one-cycle interrupt whenever any unit finishes or times out.
module md5_unit_tracker
    import md5_unit_tracker_pkg::*;
#(
    parameter int NUM_UNITS      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_UNITS-1:0] ctl_start,
    input  logic [NUM_UNITS-1:0] ctl_reset,
    input  logic [NUM_UNITS-1:0] core_done,
    output logic [NUM_UNITS-1:0] core_start,
    output logic [NUM_UNITS-1:0] core_reset,
    output logic [NUM_UNITS-1:0] md5_done,
    output logic [NUM_UNITS-1:0] busy,
    output logic [NUM_UNITS-1:0] timeout,
    output logic                 irq
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [NUM_UNITS-1:0] enter_final;
    logic                 irq_q;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
        md5_unit_tracker_slot #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .ctl_start_i   (ctl_start[i]),
            .ctl_reset_i   (ctl_reset[i]),
            .core_done_i   (core_done[i]),
            .core_start_o  (core_start[i]),
            .core_reset_o  (core_reset[i]),
            .md5_done_o    (md5_done[i]),
            .busy_o        (busy[i]),
            .timeout_o     (timeout[i]),
            .enter_final_o (enter_final[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |enter_final;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_md5_unit_tracker.sv
// Directed bench for md5_unit_tracker: each step queues the outputs expected after
// the next clock edge, then pops and compares them once that edge has passed.
module tb_md5_unit_tracker;

    localparam int N  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] ctl_start, ctl_reset, core_done;
    logic [N-1:0] core_start, core_reset, md5_done, busy, timeout;
    logic         irq;

    typedef struct packed {
        logic [N-1:0] cs;
        logic [N-1:0] cr;
        logic [N-1:0] md;
        logic [N-1:0] bz;
        logic [N-1:0] to;
        logic         irq;
    } exp_t;

    exp_t sb[$];
    logic [N-1:0] e_cs, e_cr, e_md, e_bz, e_to;
    logic         e_irq;
    int           tests_run = 0;
    int           tests_failed = 0;

    md5_unit_tracker #(
        .NUM_UNITS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ctl_start  (ctl_start),
        .ctl_reset  (ctl_reset),
        .core_done  (core_done),
        .core_start (core_start),
        .core_reset (core_reset),
        .md5_done   (md5_done),
        .busy       (busy),
        .timeout    (timeout),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag);
        exp_t e;
        e = '{cs: e_cs, cr: e_cr, md: e_md, bz: e_bz, to: e_to, irq: e_irq};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests_run += 6;
        assert (core_start === e.cs) else begin
            tests_failed++;
            $error("FAIL %s core_start got %h exp %h", tag, core_start, e.cs);
        end
        assert (core_reset === e.cr) else begin
            tests_failed++;
            $error("FAIL %s core_reset got %h exp %h", tag, core_reset, e.cr);
        end
        assert (md5_done === e.md) else begin
            tests_failed++;
            $error("FAIL %s md5_done got %h exp %h", tag, md5_done, e.md);
        end
        assert (busy === e.bz) else begin
            tests_failed++;
            $error("FAIL %s busy got %h exp %h", tag, busy, e.bz);
        end
        assert (timeout === e.to) else begin
            tests_failed++;
            $error("FAIL %s timeout got %h exp %h", tag, timeout, e.to);
        end
        assert (irq === e.irq) else begin
            tests_failed++;
            $error("FAIL %s irq got %b exp %b", tag, irq, e.irq);
        end
        ctl_start = '0;
        ctl_reset = '0;
        e_cs      = '0;
        e_cr      = '0;
        e_irq     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        ctl_start = '0;
        ctl_reset = '0;
        core_done = '0;
        e_cs = '0; e_cr = '0; e_md = '0; e_bz = '0; e_to = '0; e_irq = 1'b0;

        // 1: reset, then idle with everything quiet
        repeat (2) cyc("t1_reset");
        reset = 1'b0;
        repeat (10) cyc("t1_idle");

        // 2: unit 0 start, core finishes a few cycles later
        ctl_start = 32'h1; e_cs = 32'h1; e_bz = 32'h1;
        cyc("t2_start");
        repeat (9) cyc("t2_run");
        core_done[0] = 1'b1; e_bz[0] = 1'b0; e_md[0] = 1'b1; e_irq = 1'b1;
        cyc("t2_done");
        repeat (3) cyc("t2_hold");

        // 3: unit 3 runs out of cycles, then a restart clears the timeout
        ctl_start = 32'h8; e_cs = 32'h8; e_bz[3] = 1'b1;
        cyc("t3_start");
        repeat (TO - 1) cyc("t3_run");
        e_bz[3] = 1'b0; e_to[3] = 1'b1; e_irq = 1'b1;
        cyc("t3_timeout");
        repeat (3) cyc("t3_hold");
        ctl_start = 32'h8; e_cs = 32'h8; e_to[3] = 1'b0; e_bz[3] = 1'b1;
        cyc("t3_restart");
        ctl_reset = 32'h8; e_cr = 32'h8; e_bz[3] = 1'b0;
        cyc("t3_reset");

        // 4: start and reset together on unit 2 resolve to reset only
        ctl_start = 32'h5; ctl_reset = 32'h4; core_done[0] = 1'b0;
        e_cs = 32'h1; e_cr = 32'h4; e_md[0] = 1'b0; e_bz[0] = 1'b1;
        cyc("t4_mixed");
        cyc("t4_after");
        ctl_reset = 32'h1; e_cr = 32'h1; e_bz[0] = 1'b0;
        cyc("t4_clear0");

        // 5: repeated start ignored in RUN; done on the final count wins over timeout
        ctl_start = 32'h2; e_cs = 32'h2; e_bz[1] = 1'b1;
        cyc("t5_start");
        cyc("t5_run");
        ctl_start = 32'h2;
        cyc("t5_restart_ignored");
        repeat (TO - 3) cyc("t5_run");
        core_done[1] = 1'b1; e_bz[1] = 1'b0; e_md[1] = 1'b1; e_irq = 1'b1;
        cyc("t5_done_wins");
        cyc("t5_hold");
        ctl_reset = 32'h2; core_done[1] = 1'b0; e_cr = 32'h2; e_md[1] = 1'b0;
        cyc("t5_clear");

        // 6: stale core_done level across a reset produces no false completion
        ctl_start = 32'h10; e_cs = 32'h10; e_bz[4] = 1'b1;
        cyc("t6_start");
        cyc("t6_run");
        core_done[4] = 1'b1; e_bz[4] = 1'b0; e_md[4] = 1'b1; e_irq = 1'b1;
        cyc("t6_done");
        ctl_start = 32'h10; e_cs = 32'h10; e_md[4] = 1'b0; e_bz[4] = 1'b1;
        cyc("t6_rerun_level_high");
        repeat (3) cyc("t6_no_edge");
        ctl_reset = 32'h10; e_cr = 32'h10; e_bz[4] = 1'b0;
        cyc("t6_reset_mid_run");
        repeat (2) cyc("t6_idle");
        ctl_start = 32'h10; e_cs = 32'h10; e_bz[4] = 1'b1;
        cyc("t6_start_again");
        repeat (4) cyc("t6_held_high");
        core_done[4] = 1'b0;
        cyc("t6_core_drop");
        core_done[4] = 1'b1; e_bz[4] = 1'b0; e_md[4] = 1'b1; e_irq = 1'b1;
        cyc("t6_core_rise");

        // completions on consecutive cycles give one irq pulse each
        ctl_start = 32'h60; e_cs = 32'h60; e_bz[6:5] = 2'b11;
        cyc("t7_start");
        core_done[5] = 1'b1; e_bz[5] = 1'b0; e_md[5] = 1'b1; e_irq = 1'b1;
        cyc("t7_done5");
        core_done[6] = 1'b1; e_bz[6] = 1'b0; e_md[6] = 1'b1; e_irq = 1'b1;
        cyc("t7_done6");
        cyc("t7_quiet");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
